ahb_apb_bridge: RTL and testbench
=================================

Name: ahb_apb_bridge

Overview:
- AHB-Lite slave to APB master bridge. It sits directly downstream of the crossbar's peripheral slave port (the periph_* signal group).
- Converts each NONSEQ/SEQ AHB transfer into one APB SETUP+ACCESS transaction.
- Stalls the AHB data phase with hreadyout until the APB peripheral returns pready.
- Only one transfer is in flight at a time. The next AHB address phase is accepted in the completing cycle.

Parameters:
- ADDR_W, 16: width of paddr; taken from haddr[ADDR_W-1:0].
- DATA_W, 32: AHB/APB data width. Only 32 is supported.

Ports:
- clk  in  1  single clock; all flops rise on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- haddr  in  32  AHB address.
- hwrite  in  1  AHB write.
- hsize  in  3  AHB size; only 0, 1 and 2 are legal.
- htrans  in  2  AHB transfer type.
- hprot  in  4  AHB protection.
- hwdata  in  32  AHB write data (data phase).
- hsel  in  1  slave select from the crossbar.
- hreadyin  in  1  bus-level hready from the crossbar.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.

Behaviour:
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata_q=0, hreadyout=1, hresp=0, FSM=IDLE.
- Transfer accept condition: acc = hsel & hreadyin & htrans[1] & hreadyout_int.
  - On acc, register haddr[ADDR_W-1:0], hwrite, hsize, haddr[1:0] and hprot.
- htrans IDLE or BUSY with hsel=1: no APB activity; zero-wait OKAY.
- FSM states:
  - IDLE: hreadyout=1.
    - acc -> SETUP.
  - SETUP: psel=1, penable=0, hreadyout=0.
    - pwdata is driven combinationally from hwdata; hwdata is captured into pwdata_q at the end of the cycle.
    - Always -> ACCESS.
  - ACCESS: psel=1, penable=1, pwdata=pwdata_q; paddr/pwrite held.
    - pready=0: stay in ACCESS, hreadyout=0.
    - pready=1, no error: hreadyout=1 combinationally; hrdata=prdata in this cycle. Then acc -> SETUP, else -> IDLE.
    - pready=1 with error (feature only): -> ERR; hreadyout=0, hresp=1.
  - ERR: hreadyout=1, hresp=1 (second cycle of the AHB two-cycle error response).
    - acc -> SETUP, else -> IDLE.
- psel/penable are registered, decoded from the next-state. psel drops in the cycle after pready unless a back-to-back SETUP follows; in that case psel stays 1 and penable drops.
- hrdata is 0 outside the ACCESS-complete cycle.
- Minimum latency: data phase = 2 cycles (SETUP + ACCESS with pready=1), i.e. 1 AHB wait state.
- Latency grows by one cycle per pready=0 cycle. There is no timeout.
- Reset asserted mid-transfer: psel and penable fall asynchronously, the FSM goes to IDLE and the transfer is dropped.
- hsize>2 is treated as a word access.

Optional Feature:
- Macro: AHB_APB_BRIDGE_APB4_EN.
- Defined, adds ports pprot[2:0], pstrb[3:0] and pslverr (in).
  - pprot = {~hprot[0], 1'b0, hprot[1]}, registered at acc.
  - pstrb for writes:
    - byte -> 1<<addr[1:0]
    - half -> 4'b0011 << {addr[1],1'b0}
    - word -> 4'b1111
  - pstrb for reads = 0.
  - pslverr=1 together with pready in ACCESS -> ERR path.
- Undefined: none of these ports exist, ERR is unreachable and hresp is tied to 0.

Decomposition:
- Shared package ahb_apb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HRESP_OKAY/ERROR constants
  - 2-bit FSM state type (IDLE, SETUP, ACCESS, ERR)
  - pstrb_decode(hsize, addr_lo) function
- No sub-module: the FSM and address/data registers form one module.

Test Plan:
- Single read:
  - Stimulus: NONSEQ read at haddr=0x0000_0104; pready=1 in first ACCESS; prdata=0xDEADBEEF.
  - Response: SETUP at cycle 1, ACCESS at cycle 2 with paddr=0x0104; hreadyout=0,1 over the data phase; hrdata=0xDEADBEEF with hresp=0.
- Wait-stated write:
  - Stimulus: NONSEQ write to 0x20, hwdata=0x12345678; pready=0 for 3 ACCESS cycles.
  - Response: pwdata=0x12345678 stable from SETUP to completion; hreadyout low for 4 cycles; psel/penable drop afterwards.
- Back-to-back:
  - Stimulus: read at 0x10, then a NONSEQ write to 0x14 presented in the completing cycle.
  - Response: psel stays 1, penable goes 1→0 into the second SETUP; second paddr=0x14.
- htrans=IDLE and BUSY with hsel=1:
  - Response: psel never asserts; hreadyout=1, hresp=0.
- Async reset during ACCESS with pready=0:
  - Response: psel=0, penable=0, hreadyout=1 immediately; the next NONSEQ after reset release completes normally.
- APB4_EN:
  - Stimulus: byte write at addr 0x3 -> pstrb=4'b1000; half write at 0x2 -> 4'b1100; pslverr=1 on a read.
  - Response: hresp=1 with hreadyout=0 then hreadyout=1, hresp=1.

Source files
------------

// File: rtl/ahb_apb_bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge: transfer/response
// encodings, the FSM state type and the APB4 byte-strobe decoder.
// Optional APB4 signalling is controlled by AHB_APB_BRIDGE_APB4_EN.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // Byte lanes touched by a write of the given size at the given low address
  // bits; anything wider than a halfword is treated as a full word.
  function automatic logic [3:0] pstrb_decode(input logic [2:0] hsize,
                                              input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (hsize)
      3'd0:    strb = 4'b0001 << addr_lo;
      3'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// Bus interfaces for the bridge: the AHB-Lite peripheral port coming from the
// crossbar and the APB port going to the peripherals.
// The APB4 sideband (pprot/pstrb/pslverr) exists only when
// AHB_APB_BRIDGE_APB4_EN is defined.
interface ahb_lite_if #(parameter int DATA_W = 32);
  import ahb_apb_pkg::*;

  logic [31:0]       haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [1:0]        htrans;
  logic [3:0]        hprot;
  logic [DATA_W-1:0] hwdata;
  logic              hsel;
  logic              hreadyin;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport slave (
    input  haddr, hwrite, hsize, htrans, hprot, hwdata, hsel, hreadyin,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output haddr, hwrite, hsize, htrans, hprot, hwdata, hsel, hreadyin,
    input  hreadyout, hresp, hrdata
  );
endinterface

interface apb_if #(parameter int ADDR_W = 16, parameter int DATA_W = 32);
  import ahb_apb_pkg::*;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
`ifdef AHB_APB_BRIDGE_APB4_EN
  logic [2:0]        pprot;
  logic [3:0]        pstrb;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pprot, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pprot, pstrb,
    output prdata, pready, pslverr
  );
`else
  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready
  );
`endif
endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge. One transfer in flight; every accepted
// NONSEQ/SEQ beat becomes one APB SETUP+ACCESS pair, and the AHB data phase is
// stalled through hreadyout until pready. The next address phase may be
// accepted in the completing cycle (back-to-back SETUP keeps psel high).
// Define AHB_APB_BRIDGE_APB4_EN for pprot/pstrb/pslverr and the ERROR path.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  ahb_lite_if.slave  ahb,
  apb_if.master      apb
);

  state_t            state_r;
  state_t            state_nxt_s;

  logic              trans_valid_s;
  logic              acc_s;
  logic              err_s;
  logic              hreadyout_s;
  logic              hresp_s;
  logic [DATA_W-1:0] hrdata_s;
  logic [DATA_W-1:0] pwdata_s;

  logic [ADDR_W-1:0] paddr_r;
  logic              pwrite_r;
  logic              psel_r;
  logic              penable_r;
  logic [DATA_W-1:0] pwdata_q_r;

  // Only NONSEQ and SEQ carry a transfer; IDLE/BUSY get a zero-wait OKAY.
  assign trans_valid_s = (ahb.htrans == HTRANS_NONSEQ) ||
                         (ahb.htrans == HTRANS_SEQ);
  assign acc_s = ahb.hsel & ahb.hreadyin & trans_valid_s & hreadyout_s;

`ifdef AHB_APB_BRIDGE_APB4_EN
  logic [2:0] pprot_r;
  logic [3:0] pstrb_r;
  logic       unused_bits_s;

  assign err_s         = apb.pslverr;
  assign unused_bits_s = ^{1'b0, ahb.haddr[31:ADDR_W], ahb.hprot[3:2]};

  // APB4 protection and byte strobes are captured with the address phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pprot_r <= 3'b000;
      pstrb_r <= 4'b0000;
    end else if (acc_s) begin
      pprot_r <= {~ahb.hprot[0], 1'b0, ahb.hprot[1]};
      pstrb_r <= ahb.hwrite ? pstrb_decode(ahb.hsize, ahb.haddr[1:0]) : 4'b0000;
    end
  end

  assign apb.pprot = pprot_r;
  assign apb.pstrb = pstrb_r;
`else
  logic unused_bits_s;

  assign err_s         = 1'b0;
  assign unused_bits_s = ^{1'b0, ahb.haddr[31:ADDR_W], ahb.hsize, ahb.hprot};
`endif

  // FSM state register; reset drops any transfer in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (acc_s) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!apb.pready) begin
          state_nxt_s = ST_ACCESS;
        end else if (err_s) begin
          state_nxt_s = ST_ERR;
        end else if (acc_s) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (acc_s) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // AHB response and APB write-data steering for the current state.
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = HRESP_OKAY;
    hrdata_s    = {DATA_W{1'b0}};
    pwdata_s    = pwdata_q_r;
    case (state_r)
      ST_IDLE: begin
        hreadyout_s = 1'b1;
      end
      ST_SETUP: begin
        // hwdata is only valid from this cycle on, so forward it directly.
        hreadyout_s = 1'b0;
        pwdata_s    = ahb.hwdata;
      end
      ST_ACCESS: begin
        if (!apb.pready) begin
          hreadyout_s = 1'b0;
        end else if (err_s) begin
          // First cycle of the two-cycle AHB error response.
          hreadyout_s = 1'b0;
          hresp_s     = HRESP_ERROR;
        end else begin
          hreadyout_s = 1'b1;
          hrdata_s    = apb.prdata;
        end
      end
      ST_ERR: begin
        hreadyout_s = 1'b1;
        hresp_s     = HRESP_ERROR;
      end
      default: begin
        hreadyout_s = 1'b1;
      end
    endcase
  end

  // psel/penable are registered from the next state so they change cleanly
  // on the clock edge; a back-to-back SETUP keeps psel and clears penable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
    end else begin
      psel_r    <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
      penable_r <= (state_nxt_s == ST_ACCESS);
    end
  end

  // Address and direction are captured at accept and held until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddr_r  <= {ADDR_W{1'b0}};
      pwrite_r <= 1'b0;
    end else if (acc_s) begin
      paddr_r  <= ahb.haddr[ADDR_W-1:0];
      pwrite_r <= ahb.hwrite;
    end
  end

  // Write data is latched at the end of SETUP so ACCESS is independent of hwdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwdata_q_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_SETUP) begin
      pwdata_q_r <= ahb.hwdata;
    end
  end

  assign ahb.hreadyout = hreadyout_s;
  assign ahb.hresp     = hresp_s;
  assign ahb.hrdata    = hrdata_s;

  assign apb.paddr     = paddr_r;
  assign apb.pwrite    = pwrite_r;
  assign apb.psel      = psel_r;
  assign apb.penable   = penable_r;
  assign apb.pwdata    = pwdata_s;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge. Inputs change on the
// falling edge and outputs are sampled 1 ns later, away from the rising edge.
// APB4 checks are compiled in with AHB_APB_BRIDGE_APB4_EN.
module tb_ahb_apb_bridge;
  import ahb_apb_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  ahb_lite_if #(.DATA_W(32)) ahb ();
  apb_if #(.ADDR_W(16), .DATA_W(32)) apb ();

  ahb_apb_bridge #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ahb     (ahb),
    .apb     (apb)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] tr_tab [3] = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ};
  logic       ry_tab [3] = '{1'b1, 1'b1, 1'b0};

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    ahb.hsel   = 1'b0;
    ahb.htrans = HTRANS_IDLE;
    ahb.haddr  = 32'h0;
    ahb.hwrite = 1'b0;
    ahb.hsize  = 3'd2;
    ahb.hprot  = 4'b0011;
    apb.pready = 1'b0;
    apb.prdata = 32'h0;
`ifdef AHB_APB_BRIDGE_APB4_EN
    apb.pslverr = 1'b0;
`endif
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w,
                            input logic [2:0] sz, input logic [3:0] prot);
    ahb.hsel   = 1'b1;
    ahb.htrans = HTRANS_NONSEQ;
    ahb.haddr  = a;
    ahb.hwrite = w;
    ahb.hsize  = sz;
    ahb.hprot  = prot;
  endtask

  task automatic no_addr();
    ahb.hsel   = 1'b0;
    ahb.htrans = HTRANS_IDLE;
  endtask

  initial begin
    reset_n      = 1'b0;
    ahb.hwdata   = 32'h0;
    ahb.hreadyin = 1'b1;
    bus_idle();

    // Reset state
    @(negedge clk); #1;
    check_val("rst_psel",    32'(apb.psel),      32'h0);
    check_val("rst_penable", 32'(apb.penable),   32'h0);
    check_val("rst_pwrite",  32'(apb.pwrite),    32'h0);
    check_val("rst_paddr",   32'(apb.paddr),     32'h0);
    check_val("rst_pwdata",  apb.pwdata,         32'h0);
    check_val("rst_hready",  32'(ahb.hreadyout), 32'h1);
    check_val("rst_hresp",   32'(ahb.hresp),     32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single read
    @(negedge clk); addr_phase(32'h0000_0104, 1'b0, 3'd2, 4'b0011); #1;
    check_val("rd_addr_hready", 32'(ahb.hreadyout), 32'h1);
    check_val("rd_addr_psel",   32'(apb.psel),      32'h0);
    @(negedge clk); no_addr(); #1;
    check_val("rd_setup_psel",    32'(apb.psel),      32'h1);
    check_val("rd_setup_penable", 32'(apb.penable),   32'h0);
    check_val("rd_setup_hready",  32'(ahb.hreadyout), 32'h0);
    check_val("rd_setup_paddr",   32'(apb.paddr),     32'h0104);
    check_val("rd_setup_pwrite",  32'(apb.pwrite),    32'h0);
    @(negedge clk); apb.pready = 1'b1; apb.prdata = 32'hDEAD_BEEF; #1;
    check_val("rd_acc_psel",    32'(apb.psel),      32'h1);
    check_val("rd_acc_penable", 32'(apb.penable),   32'h1);
    check_val("rd_acc_hready",  32'(ahb.hreadyout), 32'h1);
    check_val("rd_acc_hrdata",  ahb.hrdata,         32'hDEAD_BEEF);
    check_val("rd_acc_hresp",   32'(ahb.hresp),     32'h0);
    @(negedge clk); apb.pready = 1'b0; apb.prdata = 32'h1111_2222; #1;
    check_val("rd_end_psel",    32'(apb.psel),    32'h0);
    check_val("rd_end_penable", 32'(apb.penable), 32'h0);
    check_val("rd_end_hrdata",  ahb.hrdata,       32'h0);

    // Wait-stated write: hwdata is deliberately removed after SETUP
    @(negedge clk); addr_phase(32'h0000_0020, 1'b1, 3'd2, 4'b0011); #1;
    @(negedge clk); no_addr(); ahb.hwdata = 32'h1234_5678; #1;
    check_val("wr_setup_pwdata", apb.pwdata,         32'h1234_5678);
    check_val("wr_setup_pwrite", 32'(apb.pwrite),    32'h1);
    check_val("wr_setup_paddr",  32'(apb.paddr),     32'h0020);
    check_val("wr_setup_hready", 32'(ahb.hreadyout), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ahb.hwdata = 32'h0; apb.prdata = 32'hFFFF_FFFF; #1;
      check_val("wr_wait_hready",  32'(ahb.hreadyout), 32'h0);
      check_val("wr_wait_penable", 32'(apb.penable),   32'h1);
      check_val("wr_wait_pwdata",  apb.pwdata,         32'h1234_5678);
      check_val("wr_wait_hrdata",  ahb.hrdata,         32'h0);
    end
    @(negedge clk); apb.pready = 1'b1; #1;
    check_val("wr_done_hready", 32'(ahb.hreadyout), 32'h1);
    check_val("wr_done_pwdata", apb.pwdata,         32'h1234_5678);
    @(negedge clk); apb.pready = 1'b0; #1;
    check_val("wr_end_psel",    32'(apb.psel),    32'h0);
    check_val("wr_end_penable", 32'(apb.penable), 32'h0);

    // Back-to-back: write presented in the completing read cycle
    @(negedge clk); addr_phase(32'h0000_0010, 1'b0, 3'd2, 4'b0011); #1;
    @(negedge clk); no_addr(); #1;
    @(negedge clk); apb.pready = 1'b1; apb.prdata = 32'hA5A5_0001;
    addr_phase(32'h0000_0014, 1'b1, 3'd2, 4'b0011); #1;
    check_val("b2b_rd_hready", 32'(ahb.hreadyout), 32'h1);
    check_val("b2b_rd_hrdata", ahb.hrdata,         32'hA5A5_0001);
    check_val("b2b_rd_paddr",  32'(apb.paddr),     32'h0010);
    @(negedge clk); apb.pready = 1'b0; no_addr(); ahb.hwdata = 32'hCAFE_F00D; #1;
    check_val("b2b_wr_psel",    32'(apb.psel),    32'h1);
    check_val("b2b_wr_penable", 32'(apb.penable), 32'h0);
    check_val("b2b_wr_paddr",   32'(apb.paddr),   32'h0014);
    check_val("b2b_wr_pwrite",  32'(apb.pwrite),  32'h1);
    check_val("b2b_wr_pwdata",  apb.pwdata,       32'hCAFE_F00D);
    @(negedge clk); apb.pready = 1'b1; #1;
    check_val("b2b_acc_penable", 32'(apb.penable),   32'h1);
    check_val("b2b_acc_hready",  32'(ahb.hreadyout), 32'h1);
    check_val("b2b_acc_pwdata",  apb.pwdata,         32'hCAFE_F00D);
    @(negedge clk); apb.pready = 1'b0; #1;
    check_val("b2b_end_psel", 32'(apb.psel), 32'h0);

    // IDLE / BUSY with hsel, and NONSEQ while hreadyin is low: no APB activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ahb.hsel = 1'b1; ahb.htrans = tr_tab[i]; ahb.haddr = 32'h0000_0030;
      ahb.hreadyin = ry_tab[i]; #1;
      check_val("noxfer_hready", 32'(ahb.hreadyout), 32'h1);
      check_val("noxfer_hresp",  32'(ahb.hresp),     32'h0);
      @(negedge clk); no_addr(); ahb.hreadyin = 1'b1; #1;
      check_val("noxfer_psel", 32'(apb.psel), 32'h0);
    end

    // Asynchronous reset in a waiting ACCESS
    @(negedge clk); addr_phase(32'h0000_0040, 1'b0, 3'd2, 4'b0011); #1;
    @(negedge clk); no_addr(); #1;
    @(negedge clk); apb.pready = 1'b0; #1;
    check_val("arst_pre_penable", 32'(apb.penable), 32'h1);
    #2 reset_n = 1'b0; #1;
    check_val("arst_psel",    32'(apb.psel),      32'h0);
    check_val("arst_penable", 32'(apb.penable),   32'h0);
    check_val("arst_hready",  32'(ahb.hreadyout), 32'h1);
    @(negedge clk); reset_n = 1'b1; #1;
    check_val("arst_rel_psel", 32'(apb.psel), 32'h0);
    @(negedge clk); addr_phase(32'h0000_0044, 1'b0, 3'd2, 4'b0011); #1;
    @(negedge clk); no_addr(); #1;
    check_val("arst_rd_psel",  32'(apb.psel),  32'h1);
    check_val("arst_rd_paddr", 32'(apb.paddr), 32'h0044);
    @(negedge clk); apb.pready = 1'b1; apb.prdata = 32'h600D_F00D; #1;
    check_val("arst_rd_hready", 32'(ahb.hreadyout), 32'h1);
    check_val("arst_rd_hrdata", ahb.hrdata,         32'h600D_F00D);
    @(negedge clk); apb.pready = 1'b0; #1;
    check_val("arst_rd_end_psel", 32'(apb.psel), 32'h0);

`ifdef AHB_APB_BRIDGE_APB4_EN
    // Byte write at 0x3
    @(negedge clk); addr_phase(32'h0000_0003, 1'b1, 3'd0, 4'b0010); #1;
    @(negedge clk); no_addr(); ahb.hwdata = 32'hAA00_0000; #1;
    check_val("apb4_byte_pstrb", 32'(apb.pstrb), 32'h8);
    check_val("apb4_byte_pprot", 32'(apb.pprot), 32'h5);
    @(negedge clk); apb.pready = 1'b1; #1;
    check_val("apb4_byte_hready", 32'(ahb.hreadyout), 32'h1);
    @(negedge clk); apb.pready = 1'b0;
    // Half write at 0x2
    addr_phase(32'h0000_0002, 1'b1, 3'd1, 4'b0011); #1;
    @(negedge clk); no_addr(); ahb.hwdata = 32'hBBBB_0000; #1;
    check_val("apb4_half_pstrb", 32'(apb.pstrb), 32'hC);
    check_val("apb4_half_pprot", 32'(apb.pprot), 32'h1);
    @(negedge clk); apb.pready = 1'b1; #1;
    @(negedge clk); apb.pready = 1'b0;
    // Read with pslverr
    addr_phase(32'h0000_0008, 1'b0, 3'd2, 4'b0011); #1;
    @(negedge clk); no_addr(); #1;
    check_val("apb4_rd_pstrb", 32'(apb.pstrb), 32'h0);
    @(negedge clk); apb.pready = 1'b1; apb.pslverr = 1'b1; apb.prdata = 32'h1234_0000; #1;
    check_val("apb4_err1_hresp",  32'(ahb.hresp),     32'h1);
    check_val("apb4_err1_hready", 32'(ahb.hreadyout), 32'h0);
    check_val("apb4_err1_hrdata", ahb.hrdata,         32'h0);
    @(negedge clk); apb.pready = 1'b0; apb.pslverr = 1'b0; #1;
    check_val("apb4_err2_hresp",  32'(ahb.hresp),     32'h1);
    check_val("apb4_err2_hready", 32'(ahb.hreadyout), 32'h1);
    check_val("apb4_err2_psel",   32'(apb.psel),      32'h0);
    @(negedge clk); #1;
    check_val("apb4_err3_hresp", 32'(ahb.hresp), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
